// File: rtl/cipher_pkg.sv
// Shared constants and sizing helpers for the key-mask cipher pipeline.
package cipher_pkg;
    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_ENC = 1'b1;

    function automatic int nseg(input int data_w, input int key_w);
        return (data_w + key_w - 1) / key_w;
    endfunction

    function automatic int pkt_w(input int key_w, input int data_w, input int pad_w);
        return key_w + 1 + data_w + pad_w;
    endfunction

    // Default configuration; packet is {key, guard, field, pad}, MSB first
    localparam int KEY_W_DEF   = 11;
    localparam int DATA_W_DEF  = 60;
    localparam int PAD_W_DEF   = 6;
    localparam int CNT_W_DEF   = 16;
    localparam int NSEG_DEF    = nseg(DATA_W_DEF, KEY_W_DEF);
    localparam int PKT_W_DEF   = pkt_w(KEY_W_DEF, DATA_W_DEF, PAD_W_DEF);
    localparam int FLD_LSB_DEF = PAD_W_DEF;
    localparam int GRD_BIT_DEF = PAD_W_DEF + DATA_W_DEF;
    localparam int KEY_LSB_DEF = GRD_BIT_DEF + 1;
    localparam logic [NSEG_DEF-1:0] INV_MSK_DEF = 6'b001100;
endpackage

// File: rtl/cipher_mask_gen.sv
// Combinational mask builder: the key repeated across DATA_W bits, with
// selected segments inverted and the top segment truncated.
module cipher_mask_gen
    import cipher_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [nseg(DATA_W, KEY_W)-1:0] INV_MSK = INV_MSK_DEF
) (
    input  logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] mask
);
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        assign mask[b] = key[b % KEY_W] ^ INV_MSK[b / KEY_W];
    end
endmodule

// File: rtl/cipher_mask_pipe.sv
// Two-stage valid/ready key-mask cipher: S1 captures and builds the mask,
// S2 adds (encrypt) or subtracts (decrypt) and holds the result for the sink.
module cipher_mask_pipe
    import cipher_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PAD_W  = PAD_W_DEF,
    parameter logic [nseg(DATA_W, KEY_W)-1:0] INV_MSK = INV_MSK_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int PKT_W = pkt_w(KEY_W, DATA_W, PAD_W)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [PKT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [PKT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int FLD_LSB = PAD_W;
    localparam int GRD_BIT = PAD_W + DATA_W;
    localparam int KEY_LSB = GRD_BIT + 1;

    logic              live;
    logic              s1_v, s2_v;
    logic [KEY_W-1:0]  s1_key;
    logic              s1_mode, s1_guard;
    logic [DATA_W-1:0] s1_field, s1_mask, mask;
    logic              s1_adv, s2_adv, in_fire, out_fire;
    logic [DATA_W:0]   r_dec, r_enc;
    logic [PKT_W-1:0]  s2_data_nxt;
    logic              s2_err_nxt;
    logic              unused_pad;

    assign unused_pad = ^in_data[PAD_W-1:0];

    // live keeps in_ready low until the first edge after reset release
    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = live && s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_v;
    assign out_fire  = s2_v && out_ready;

    cipher_mask_gen #(
        .KEY_W  (KEY_W),
        .DATA_W (DATA_W),
        .INV_MSK(INV_MSK)
    ) u_mask (
        .key (in_data[KEY_LSB +: KEY_W]),
        .mask(mask)
    );

    assign r_dec       = {s1_guard, s1_field} - {1'b0, s1_mask};
    assign r_enc       = {1'b0, s1_field} + {1'b0, s1_mask};
    assign s2_data_nxt = (s1_mode == MODE_ENC) ? {s1_key, r_enc, {PAD_W{1'b0}}}
                                               : {{(PKT_W-DATA_W){1'b0}}, r_dec[DATA_W-1:0]};
    assign s2_err_nxt  = (s1_mode == MODE_DEC) && r_dec[DATA_W];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            live     <= 1'b0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_key   <= '0;
            s1_mode  <= 1'b0;
            s1_guard <= 1'b0;
            s1_field <= '0;
            s1_mask  <= '0;
            out_mode <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            live <= 1'b1;
            if (s1_adv) begin
                s1_v <= in_fire;
                if (in_fire) begin
                    s1_key   <= in_data[KEY_LSB +: KEY_W];
                    s1_mode  <= in_mode;
                    s1_guard <= in_data[GRD_BIT];
                    s1_field <= in_data[FLD_LSB +: DATA_W];
                    s1_mask  <= mask;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_mode <= s1_mode;
                    out_data <= s2_data_nxt;
                    out_err  <= s2_err_nxt;
                end
            end
            if (out_fire) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
                if (out_err && (err_cnt != {CNT_W{1'b1}}))
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
endmodule
